icache: RTL and testbench

- Direct-mapped instruction cache between the fetch stage and the memory controller's decoder port.
- Serves fetch requests on a hit without a memory access.
- On a miss, issues one request to the memory controller and stores the returned instruction (already expanded if compressed) together with its compressed flag.
- Cache contents are unaffected by branch flush.

---
 rtl/icache.sv | 173 +++++++++++++++++
 tb/tb_icache.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped, one-instruction-per-line instruction cache between fetch and the memory decoder port.
// Define ICACHE_PERF_EN to add saturating hit_count/miss_count outputs.
module icache #(
    parameter int INDEX_WIDTH = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush,
    input  logic        invalidate_all,
    input  logic        fetch_en,
    input  logic [31:0] fetch_addr,
    output logic        fetch_rdy,
    output logic [31:0] fetch_inst,
    output logic        fetch_is_compressed,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    input  logic        mem_rdy,
    input  logic [31:0] mem_data,
`ifdef ICACHE_PERF_EN
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
`endif
    input  logic        mem_is_compressed
);

    localparam int TAG_WIDTH = 31 - INDEX_WIDTH;
    localparam int LINES     = 1 << INDEX_WIDTH;

    typedef enum logic [1:0] {IDLE, MISS, DONE} state_t;

    state_t                 state_q, state_d;
    logic                   fetch_rdy_q, fetch_rdy_d;
    logic [31:0]            fetch_inst_q, fetch_inst_d;
    logic                   fetch_comp_q, fetch_comp_d;
    logic                   mem_en_q, mem_en_d;
    logic [31:0]            mem_addr_q, mem_addr_d;
    logic [LINES-1:0]       valid_q, valid_d;

    logic [TAG_WIDTH-1:0]   tag_mem  [LINES];
    logic [31:0]            inst_mem [LINES];
    logic                   comp_mem [LINES];

    logic [INDEX_WIDTH-1:0] req_idx, fill_idx;
    logic [TAG_WIDTH-1:0]   req_tag, fill_tag;
    logic                   hit;
    logic                   fill_we;
    logic                   hit_acc, miss_acc;

    assign req_idx  = fetch_addr[INDEX_WIDTH:1];
    assign req_tag  = fetch_addr[31:INDEX_WIDTH+1];
    // The fill targets the address latched at miss time, not the live fetch bus.
    assign fill_idx = mem_addr_q[INDEX_WIDTH:1];
    assign fill_tag = mem_addr_q[31:INDEX_WIDTH+1];
    assign hit      = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

    always_comb begin
        state_d      = state_q;
        fetch_rdy_d  = fetch_rdy_q;
        fetch_inst_d = fetch_inst_q;
        fetch_comp_d = fetch_comp_q;
        mem_en_d     = mem_en_q;
        mem_addr_d   = mem_addr_q;
        valid_d      = valid_q;
        fill_we      = 1'b0;
        hit_acc      = 1'b0;
        miss_acc     = 1'b0;

        if (flush && rdy_in) begin
            state_d     = IDLE;
            fetch_rdy_d = 1'b0;
            mem_en_d    = 1'b0;
        end else if (rdy_in) begin
            unique case (state_q)
                IDLE: begin
                    if (fetch_en && hit) begin
                        hit_acc      = 1'b1;
                        fetch_inst_d = inst_mem[req_idx];
                        fetch_comp_d = comp_mem[req_idx];
                        fetch_rdy_d  = 1'b1;
                        state_d      = DONE;
                    end else if (fetch_en) begin
                        miss_acc   = 1'b1;
                        mem_en_d   = 1'b1;
                        mem_addr_d = fetch_addr;
                        state_d    = MISS;
                    end
                end
                MISS: begin
                    if (mem_rdy) begin
                        fill_we      = 1'b1;
                        valid_d[fill_idx] = 1'b1;
                        fetch_inst_d = mem_data;
                        fetch_comp_d = mem_is_compressed;
                        fetch_rdy_d  = 1'b1;
                        mem_en_d     = 1'b0;
                        state_d      = DONE;
                    end
                end
                DONE: begin
                    fetch_rdy_d = 1'b0;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
            // Invalidate overrides a same-edge fill's valid bit.
            if (invalidate_all) valid_d = '0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            fetch_rdy_q  <= 1'b0;
            fetch_inst_q <= '0;
            fetch_comp_q <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_addr_q   <= '0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            fetch_rdy_q  <= fetch_rdy_d;
            fetch_inst_q <= fetch_inst_d;
            fetch_comp_q <= fetch_comp_d;
            mem_en_q     <= mem_en_d;
            mem_addr_q   <= mem_addr_d;
            valid_q      <= valid_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (fill_we) begin
            tag_mem[fill_idx]  <= fill_tag;
            inst_mem[fill_idx] <= mem_data;
            comp_mem[fill_idx] <= mem_is_compressed;
        end
    end

    assign fetch_rdy           = fetch_rdy_q;
    assign fetch_inst          = fetch_inst_q;
    assign fetch_is_compressed = fetch_comp_q;
    assign mem_en              = mem_en_q;
    assign mem_addr            = mem_addr_q;

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (hit_acc && hit_count_q != 32'hFFFF_FFFF)   hit_count_d  = hit_count_q + 32'd1;
        if (miss_acc && miss_count_q != 32'hFFFF_FFFF) miss_count_d = miss_count_q + 32'd1;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`else
    logic unused_acc;
    assign unused_acc = hit_acc ^ miss_acc;
`endif

endmodule

// File: tb/tb_icache.sv
// Directed plus randomized bench for icache against an address-level cache model.
module tb_icache;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush;
    logic        invalidate_all;
    logic        fetch_en;
    logic [31:0] fetch_addr;
    logic        fetch_rdy;
    logic [31:0] fetch_inst;
    logic        fetch_is_compressed;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic        mem_rdy;
    logic [31:0] mem_data;
    logic        mem_is_compressed;
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Model: one line per (addr/2)%16, remembering the full line address (addr/32) as tag.
    bit          m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_inst  [16];
    bit          m_comp  [16];

    icache dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .rdy_in              (rdy_in),
        .flush               (flush),
        .invalidate_all      (invalidate_all),
        .fetch_en            (fetch_en),
        .fetch_addr          (fetch_addr),
        .fetch_rdy           (fetch_rdy),
        .fetch_inst          (fetch_inst),
        .fetch_is_compressed (fetch_is_compressed),
        .mem_en              (mem_en),
        .mem_addr            (mem_addr),
        .mem_rdy             (mem_rdy),
        .mem_data            (mem_data),
`ifdef ICACHE_PERF_EN
        .hit_count           (hit_count),
        .miss_count          (miss_count),
`endif
        .mem_is_compressed   (mem_is_compressed)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] mdata, input logic mc,
                            input int dly, input logic inv_at_fill);
        int          idx;
        logic [31:0] tg;
        bit          exp_hit;
        idx     = int'((addr / 2) % 16);
        tg      = addr / 32;
        exp_hit = m_valid[idx] && (m_tag[idx] == tg);
        fetch_en   = 1'b1;
        fetch_addr = addr;
        tick();
        if (exp_hit) begin
            check("hit_rdy", {31'd0, fetch_rdy}, 32'd1);
            check("hit_inst", fetch_inst, m_inst[idx]);
            check("hit_comp", {31'd0, fetch_is_compressed}, {31'd0, m_comp[idx]});
            check("hit_mem_en", {31'd0, mem_en}, 32'd0);
            fetch_en = 1'b0;
        end else begin
            check("miss_mem_en", {31'd0, mem_en}, 32'd1);
            check("miss_mem_addr", mem_addr, addr);
            check("miss_rdy_low", {31'd0, fetch_rdy}, 32'd0);
            repeat (dly) begin
                tick();
                check("miss_wait_en", {31'd0, mem_en}, 32'd1);
                check("miss_wait_rdy", {31'd0, fetch_rdy}, 32'd0);
            end
            mem_rdy           = 1'b1;
            mem_data          = mdata;
            mem_is_compressed = mc;
            invalidate_all    = inv_at_fill;
            tick();
            mem_rdy        = 1'b0;
            invalidate_all = 1'b0;
            fetch_en       = 1'b0;
            check("fill_rdy", {31'd0, fetch_rdy}, 32'd1);
            check("fill_inst", fetch_inst, mdata);
            check("fill_comp", {31'd0, fetch_is_compressed}, {31'd0, mc});
            check("fill_mem_en", {31'd0, mem_en}, 32'd0);
            if (inv_at_fill) begin
                model_clear();
            end else begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tg;
                m_inst[idx]  = mdata;
                m_comp[idx]  = mc;
            end
        end
        tick();
        check("done_rdy_low", {31'd0, fetch_rdy}, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0; invalidate_all = 1'b0;
        fetch_en = 1'b0; fetch_addr = '0; mem_rdy = 1'b0; mem_data = '0; mem_is_compressed = 1'b0;
        model_clear();
        repeat (2) @(posedge clk_in);
        #1;
        check("rst_fetch_rdy", {31'd0, fetch_rdy}, 32'd0);
        check("rst_fetch_inst", fetch_inst, 32'd0);
        check("rst_fetch_comp", {31'd0, fetch_is_compressed}, 32'd0);
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        rst_in = 1'b0;
        tick();

        // Cold miss, hit, compressed fill, conflict eviction
        do_fetch(32'h10, 32'h00A00093, 1'b0, 2, 1'b0);
        do_fetch(32'h10, 32'h0, 1'b0, 0, 1'b0);
        do_fetch(32'h12, 32'h00108093, 1'b1, 1, 1'b0);
        do_fetch(32'h12, 32'h0, 1'b0, 0, 1'b0);
        do_fetch(32'h32, 32'h12345678, 1'b0, 0, 1'b0);
        do_fetch(32'h12, 32'h00108093, 1'b1, 3, 1'b0);

        // Flush in the same cycle as mem_rdy
        fetch_en = 1'b1; fetch_addr = 32'h40;
        tick();
        check("flush_mem_en", {31'd0, mem_en}, 32'd1);
        mem_rdy = 1'b1; mem_data = 32'hDEADBEEF; flush = 1'b1;
        tick();
        check("flush_rdy", {31'd0, fetch_rdy}, 32'd0);
        check("flush_mem_en_low", {31'd0, mem_en}, 32'd0);
        mem_rdy = 1'b0; flush = 1'b0; fetch_en = 1'b0;
        tick();
        check("flush_idle_rdy", {31'd0, fetch_rdy}, 32'd0);
        check("flush_idle_mem_en", {31'd0, mem_en}, 32'd0);
        do_fetch(32'h40, 32'h00000013, 1'b0, 1, 1'b0);

        // Invalidate while idle, then invalidate coinciding with a fill
        invalidate_all = 1'b1;
        tick();
        invalidate_all = 1'b0;
        model_clear();
        do_fetch(32'h10, 32'h00A00093, 1'b0, 0, 1'b0);
        do_fetch(32'h14, 32'h00200113, 1'b0, 1, 1'b1);
        do_fetch(32'h14, 32'h00200113, 1'b0, 0, 1'b0);

        // Stall during MISS with mem_rdy already high
        fetch_en = 1'b1; fetch_addr = 32'h20;
        tick();
        check("stall_mem_en", {31'd0, mem_en}, 32'd1);
        rdy_in = 1'b0; mem_rdy = 1'b1; mem_data = 32'h0FF00513; mem_is_compressed = 1'b1;
        repeat (3) begin
            tick();
            check("stall_hold_en", {31'd0, mem_en}, 32'd1);
            check("stall_hold_rdy", {31'd0, fetch_rdy}, 32'd0);
            check("stall_hold_addr", mem_addr, 32'h20);
        end
        rdy_in = 1'b1;
        tick();
        check("stall_fill_rdy", {31'd0, fetch_rdy}, 32'd1);
        check("stall_fill_inst", fetch_inst, 32'h0FF00513);
        check("stall_fill_comp", {31'd0, fetch_is_compressed}, 32'd1);
        mem_rdy = 1'b0; fetch_en = 1'b0; mem_is_compressed = 1'b0;
        m_valid[0] = 1'b1; m_tag[0] = 32'h1; m_inst[0] = 32'h0FF00513; m_comp[0] = 1'b1;
        tick();
        check("stall_done_rdy", {31'd0, fetch_rdy}, 32'd0);
        do_fetch(32'h20, 32'h0, 1'b0, 0, 1'b0);

        // Randomized traffic, including the top of the address space
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0:       a = 32'hFFFFFFE0;
                1:       a = 32'h00000000;
                2:       a = 32'h00000020;
                default: a = 32'h80000040;
            endcase
            a = a | ($urandom_range(0, 15) << 1) | 32'($urandom_range(0, 1));
            d = $urandom;
            if ($urandom_range(0, 9) == 0) begin
                invalidate_all = 1'b1;
                tick();
                invalidate_all = 1'b0;
                model_clear();
            end
            do_fetch(a, d, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                     1'($urandom_range(0, 11) == 0));
        end
        do_fetch(32'hFFFFFFFE, 32'hCAFEF00D, 1'b1, 0, 1'b0);
        do_fetch(32'hFFFFFFFE, 32'h0, 1'b0, 0, 1'b0);

        // Asynchronous reset mid-miss
        do_fetch(32'h10, 32'h00A00093, 1'b0, 0, 1'b0);
        fetch_en = 1'b1; fetch_addr = 32'h50;
        tick();
        check("arst_pre_mem_en", {31'd0, mem_en}, 32'd1);
        #3 rst_in = 1'b1;
        #1;
        check("arst_mem_en", {31'd0, mem_en}, 32'd0);
        check("arst_fetch_rdy", {31'd0, fetch_rdy}, 32'd0);
        check("arst_mem_addr", mem_addr, 32'd0);
        fetch_en = 1'b0;
        @(posedge clk_in);
        #1 rst_in = 1'b0;
        model_clear();
`ifdef ICACHE_PERF_EN
        check("perf_rst_hit", hit_count, 32'd0);
        check("perf_rst_miss", miss_count, 32'd0);
`endif
        do_fetch(32'h10, 32'h00A00093, 1'b0, 1, 1'b0);
        do_fetch(32'h10, 32'h0, 1'b0, 0, 1'b0);
`ifdef ICACHE_PERF_EN
        check("perf_hit", hit_count, 32'd1);
        check("perf_miss", miss_count, 32'd1);
`endif
        do_fetch(32'h20, 32'h00000073, 1'b0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
